// File: rtl/bcd_to_binary_seq_pkg.sv
// rtl/bcd_to_binary_seq_pkg.sv - shared types, constants and width helper for the BCD-to-binary converter
// Optional macro BCD_CHECK_EN selects the digit-range check and the matching width bound.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

  // Smallest output width that can hold the largest reachable result.
  function automatic int min_bin_w(input int digits);
    longint pow;
    longint max_val;
    int     w;
    pow = 1;
    for (int i = 0; i < digits; i++) pow = pow * 10;
`ifdef BCD_CHECK_EN
    max_val = pow - 1;
`else
    max_val = (15 * (pow - 1)) / 9;
`endif
    w = 1;
    while ((longint'(1) << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// rtl/bcd_to_binary_seq_if.sv - input/output valid-ready bundle of the BCD-to-binary converter
// Optional macro BCD_CHECK_EN (affects only the default BIN_W).
interface bcd_to_binary_seq_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = min_bin_w(DIGITS)
);

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err
  );

endinterface

// File: rtl/bcd_to_binary_seq_digit_mac.sv
// rtl/bcd_to_binary_seq_digit_mac.sv - combinational acc*10 + digit step
// Optional macro BCD_CHECK_EN adds the digit_bad flag.
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0]   acc_in,
  input  logic [DIGIT_W-1:0] digit,
`ifdef BCD_CHECK_EN
  output logic               digit_bad,
`endif
  output logic [BIN_W-1:0]   acc_out
);

  logic [BIN_W+3:0] acc_ext;
  logic [BIN_W+3:0] wide;
  logic             unused_hi;

  // The width rule guarantees the top four bits are always zero.
  assign acc_ext   = {4'b0000, acc_in};
  assign wide      = (acc_ext << 3) + (acc_ext << 1) + {{BIN_W{1'b0}}, digit};
  assign acc_out   = wide[BIN_W-1:0];
  assign unused_hi = ^wide[BIN_W+3:BIN_W];

`ifdef BCD_CHECK_EN
  assign digit_bad = (digit > BCD_MAX_DIGIT);
`endif

endmodule

// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - sequential packed-BCD to binary converter, one digit per clock, MSD first
// Optional macro BCD_CHECK_EN enables the sticky digit-range error.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = min_bin_w(DIGITS)
) (
  input  logic                clk,
  input  logic                rst,
  bcd_to_binary_seq_if.slave  bus
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (DIGITS < 1 || DIGITS > 8) begin : g_digits_check
    $error("bcd_to_binary_seq: DIGITS must be 1..8");
  end
  if (BIN_W < min_bin_w(DIGITS)) begin : g_bin_w_check
    $error("bcd_to_binary_seq: BIN_W too small for DIGITS");
  end

  state_t              state;
  state_t              state_n;
  logic [BIN_W-1:0]    acc;
  logic [BIN_W-1:0]    mac_out;
  logic [CNT_W-1:0]    cnt;
  logic [4*DIGITS-1:0] sreg;
  logic [DIGIT_W-1:0]  digit;
  logic                err_q;
  logic                bad_now;
  logic                in_ready;
  logic                out_valid;

  // The most significant remaining digit always sits at the top of sreg.
  assign digit = sreg[4*DIGITS-1 -: DIGIT_W];

`ifdef BCD_CHECK_EN
  logic digit_bad;

  bcd_digit_mac #(.BIN_W(BIN_W)) u_mac (
    .acc_in    (acc),
    .digit     (digit),
    .digit_bad (digit_bad),
    .acc_out   (mac_out)
  );

  assign bad_now = err_q | digit_bad;
`else
  bcd_digit_mac #(.BIN_W(BIN_W)) u_mac (
    .acc_in  (acc),
    .digit   (digit),
    .acc_out (mac_out)
  );

  assign bad_now = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_n = CONV;
      end
      CONV: begin
        if (cnt == '0) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      sreg  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sreg  <= bus.bcd_in;
            acc   <= '0;
            err_q <= 1'b0;
            cnt   <= CNT_W'(DIGITS - 1);
          end
        end
        CONV: begin
          sreg  <= sreg << DIGIT_W;
          cnt   <= cnt - 1'b1;
          err_q <= bad_now;
          // A bad word reports zero so the sink never consumes a bogus value.
          acc   <= (cnt == '0 && bad_now) ? '0 : mac_out;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.bin_out   = acc;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb/tb_bcd_to_binary_seq.sv - scoreboard bench for bcd_to_binary_seq (honours BCD_CHECK_EN)
module tb_bcd_to_binary_seq;

`ifdef BCD_CHECK_EN
  localparam int BW = 14;
`else
  localparam int BW = 15;
`endif
  localparam int ND = 4;

  typedef struct {
    logic [31:0] bin;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  bcd_to_binary_seq_if #(.DIGITS(ND), .BIN_W(BW)) bif ();

  bcd_to_binary_seq #(.DIGITS(ND), .BIN_W(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] w);
    exp_t        e;
    logic [31:0] acc;
    logic        bad;
    logic [3:0]  d;
    acc = 0;
    bad = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      d   = w[4*i +: 4];
      acc = acc * 10 + 32'(d);
      if (d > 4'd9) bad = 1'b1;
    end
`ifdef BCD_CHECK_EN
    e.err = bad;
    e.bin = bad ? 32'd0 : acc;
`else
    e.err = 1'b0;
    e.bin = acc;
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    tests++;
    assert (exp_q.size() > 0) else begin
      fails++;
      $error("FAIL %s_queue observed=%0d expected=%0d", tag, 0, 1);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_bin"}, 32'(bif.bin_out), e.bin);
      check({tag, "_err"}, 32'(bif.err), 32'(e.err));
    end
  endtask

  task automatic wait_out(input string tag, input int want_lat);
    int lat;
    lat = 0;
    while (!bif.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(want_lat));
  endtask

  task automatic run_word(input logic [15:0] w, input string tag, input logic [31:0] want_bin, input logic want_err);
    check({tag, "_in_ready_pre"}, 32'(bif.in_ready), 32'd1);
    bif.bcd_in    = w;
    bif.in_valid  = 1'b1;
    bif.out_ready = 1'b1;
    exp_q.push_back(model(w));
    tick();
    bif.in_valid = 1'b0;
    bif.bcd_in   = 16'hFFFF;
    wait_out(tag, ND);
    check({tag, "_bin_const"}, 32'(bif.bin_out), want_bin);
    check({tag, "_err_const"}, 32'(bif.err), 32'(want_err));
    pop_check(tag);
    tick();
    check({tag, "_in_ready_post"}, 32'(bif.in_ready), 32'd1);
    check({tag, "_out_valid_post"}, 32'(bif.out_valid), 32'd0);
  endtask

  initial begin
    int          sent;
    int          got;
    int          cyc;
    int          overlap;
    bit          stray;
    logic [15:0] w;
    exp_t        e;

    bif.in_valid  = 1'b0;
    bif.bcd_in    = '0;
    bif.out_ready = 1'b0;
    repeat (3) tick();
    check("reset_in_ready", 32'(bif.in_ready), 32'd1);
    check("reset_out_valid", 32'(bif.out_valid), 32'd0);
    check("reset_bin_out", 32'(bif.bin_out), 32'd0);
    check("reset_err", 32'(bif.err), 32'd0);
    rst = 1'b0;
    tick();

    run_word(16'h1234, "w1234", 32'd1234, 1'b0);
    run_word(16'h9999, "w9999", 32'd9999, 1'b0);
    run_word(16'h0000, "w0000", 32'd0, 1'b0);
    run_word(16'h0001, "w0001", 32'd1, 1'b0);
`ifdef BCD_CHECK_EN
    run_word(16'h12A4, "w12a4", 32'd0, 1'b1);
`else
    run_word(16'h12A4, "w12a4", 32'd1304, 1'b0);
`endif

    // Backpressure: result held while a competing word is offered and ignored.
    bif.bcd_in    = 16'h0500;
    bif.in_valid  = 1'b1;
    bif.out_ready = 1'b0;
    exp_q.push_back(model(16'h0500));
    tick();
    bif.in_valid = 1'b0;
    wait_out("bp", ND);
    for (int i = 0; i < 5; i++) begin
      bif.in_valid = 1'b1;
      bif.bcd_in   = 16'h0777;
      check("bp_hold_bin", 32'(bif.bin_out), 32'd500);
      check("bp_hold_in_ready", 32'(bif.in_ready), 32'd0);
      check("bp_hold_out_valid", 32'(bif.out_valid), 32'd1);
      tick();
    end
    bif.in_valid  = 1'b0;
    pop_check("bp");
    bif.out_ready = 1'b1;
    tick();
    check("bp_in_ready_post", 32'(bif.in_ready), 32'd1);
    stray = 1'b0;
    repeat (8) begin
      if (bif.out_valid) stray = 1'b1;
      tick();
    end
    check("bp_no_stray_result", 32'(stray), 32'd0);

    // Reset during the second CONV cycle discards the word.
    bif.bcd_in   = 16'h4321;
    bif.in_valid = 1'b1;
    tick();
    bif.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_in_ready", 32'(bif.in_ready), 32'd1);
    check("rst_mid_out_valid", 32'(bif.out_valid), 32'd0);
    check("rst_mid_err", 32'(bif.err), 32'd0);
    stray = 1'b0;
    repeat (8) begin
      if (bif.out_valid) stray = 1'b1;
      tick();
    end
    check("rst_mid_no_result", 32'(stray), 32'd0);
    run_word(16'h0042, "w0042", 32'd42, 1'b0);

    // Random stream with random valid and ready on both sides.
    sent    = 0;
    got     = 0;
    cyc     = 0;
    overlap = 0;
    while (got < 1000 && cyc < 60000) begin
      for (int i = 0; i < 4; i++)
        w[4*i +: 4] = ($urandom_range(0, 99) < 90) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      bif.bcd_in    = w;
      bif.in_valid  = (sent < 1000) && ($urandom_range(0, 99) < 60);
      bif.out_ready = ($urandom_range(0, 99) < 60);
      if (bif.in_ready && bif.out_valid) overlap++;
      if (bif.in_valid && bif.in_ready) begin
        exp_q.push_back(model(w));
        sent++;
      end
      if (bif.out_valid && bif.out_ready) begin
        pop_check("rand");
        got++;
      end
      tick();
      cyc++;
    end
    bif.in_valid = 1'b0;
    check("rand_results", 32'(got), 32'd1000);
    check("rand_ready_valid_overlap", 32'(overlap), 32'd0);
    check("rand_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
Sequential packed-BCD to binary converter. It is the inverse path of the team's binary-to-decimal converter and feeds BCD operands into the binary adder datapath.
- Processes one BCD digit per clock, most-significant digit first: acc = acc*10 + digit.
- Valid/ready handshake on both input and output sides.

Parameters:
- DIGITS, 4, number of BCD digits in the input word (1..8).
- BIN_W, 14, output width in bits; must be >= ceil(log2(10^DIGITS)). Elaboration-time check fails otherwise.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  source has a BCD word on bcd_in.
- in_ready  output  1  converter can accept a word; high only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD; digit 0 in bits [3:0].
- out_valid  output  1  bin_out/err are valid; high only in DONE.
- out_ready  input  1  sink accepts the result.
- bin_out  output  BIN_W  converted binary value.
- err  output  1  an input digit exceeded 9 (see Optional Feature).

Behaviour:
- Reset: synchronous, active-high. Sampled only on a clk rising edge.
  - Forces state IDLE; clears acc, digit counter, captured word and err.
  - Outputs after reset: in_ready=1, out_valid=0, bin_out=0, err=0.
  - Reset mid-conversion or in DONE discards the word. No output is ever produced for it.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture bcd_in into a shift register, clear acc and err, set cnt=DIGITS-1, go to CONV.
  - CONV: each cycle, acc <= acc*10 + digit[cnt].
    - Implement *10 as (acc<<3)+(acc<<1), computed at BIN_W+4 bits and truncated to BIN_W. It cannot overflow given the BIN_W rule.
    - cnt decrements each cycle. When cnt==0 is processed, go to DONE.
  - DONE: out_valid=1. bin_out and err are held stable until out_valid&out_ready, then go to IDLE.
- Latency and throughput:
  - out_valid rises exactly DIGITS rising edges after the accepting edge.
  - in_ready returns the cycle after the output handshake.
  - One conversion per DIGITS+2 cycles minimum; no overlap between conversions.
- Backpressure: out_ready low in DONE holds all outputs indefinitely; in_ready stays 0.
- in_valid while not in IDLE: ignored; bcd_in is not sampled.
- in_valid deasserted in IDLE: no state change.
- in_ready and out_valid are never high in the same cycle.
- bin_out is a registered output. It is 0 outside DONE, unless the implementation registers it directly from acc. Verification checks it only while out_valid=1.

Optional Feature:
- Macro: BCD_CHECK_EN.
- Defined:
  - Each digit is compared against 9 as it is processed in CONV; any digit >9 sets a sticky err.
  - In DONE with err=1, bin_out=0.
- Undefined:
  - No digit check; err tied to 0.
  - Digits 10..15 are used arithmetically as-is, e.g. 0x12A4 -> 1304.
  - BIN_W must then be >= ceil(log2(15*(10^DIGITS-1)/9+1)). The elaboration check uses this bound.

Decomposition:
- Package bcd_pkg:
  - state enum (IDLE, CONV, DONE);
  - DIGIT_W=4;
  - BCD_MAX_DIGIT=4'd9;
  - a function computing the minimum BIN_W for a given DIGITS, used by the elaboration check.
- One natural sub-module, bcd_digit_mac. It is purely combinational: acc_out = acc_in*10 + digit, plus a digit_bad flag (compiled only under BCD_CHECK_EN).
- The top holds the FSM, counter, shift register and handshake.

Test Plan:
- Reset, then bcd_in=0x1234 with in_valid for 1 cycle, out_ready=1 -> out_valid exactly 4 edges later; bin_out=1234 (0x04D2), err=0; in_ready=1 the cycle after.
- bcd_in=0x9999 -> bin_out=9999 (0x270F). Then bcd_in=0x0000 -> bin_out=0. Then 0x0001 -> 1. Each has correct latency.
- 0x12A4:
  - BCD_CHECK_EN defined -> err=1, bin_out=0.
  - Undefined -> err=0, bin_out=1304.
- Backpressure: 0x0500 with out_ready low for 5 cycles after out_valid -> bin_out=500 stable, in_ready=0. A new in_valid during this window is ignored, and its bcd_in is never converted.
- Assert rst on the 2nd CONV cycle of 0x4321 -> next cycle in_ready=1, out_valid=0, err=0. No result for 0x4321 ever appears. A subsequent 0x0042 yields 42.
- Back-to-back random stream (1000 words, random in_valid/out_ready) vs reference model -> every accepted word produces exactly one correct result, in order.
